// File: rtl/reaction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_sequencer
//  Purpose  : Reaction-time game sequencer. A start press arms a random
//             pre-GO delay (MIN_DELAY_MS + 10-bit LFSR value, in ms). The GO
//             light then comes on and the elapsed time is counted in ms until
//             stop is pressed (DONE), stop comes too early (FOUL) or the GO
//             phase runs past TIMEOUT_MS (TIMEOUT). The lowest result is kept
//             as the best time until reset.
//  Ports    : clk          - system clock, rising-edge active
//             rst_n        - synchronous active-low reset
//             start_btn    - one-cycle start pulse (pre-synchronized)
//             stop_btn     - one-cycle stop pulse (pre-synchronized)
//             state        - IDLE=0 WAIT=1 GO=2 DONE=3 FOUL=4 TIMEOUT=5
//             go_led       - lit only in GO
//             err_led      - lit only in FOUL or TIMEOUT
//             result_valid - one-cycle pulse on DONE entry
//             disp_value   - binary value for the display, <= 9999
//             best_time    - best reaction time in ms, 0 = no record
//  Revision : 1.0 - initial release
// ============================================================================
module reaction_sequencer #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 9999   // must not exceed 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        stop_btn,
  output logic [2:0]  state,
  output logic        go_led,
  output logic        err_led,
  output logic        result_valid,
  output logic [13:0] disp_value,
  output logic [13:0] best_time
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_DONE    = 3'd3,
    S_FOUL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  localparam int PRE_W = $clog2(CLKS_PER_MS + 1);
  localparam int DLY_W = $clog2(MIN_DELAY_MS + 1024);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [DLY_W-1:0] DLY_MIN     = DLY_W'(MIN_DELAY_MS);
  localparam logic [13:0]      TIMEOUT_VAL = 14'(TIMEOUT_MS);
  localparam logic [13:0]      DISP_MAX    = 14'd9999;

  state_t             state_q, state_d;
  logic [9:0]         lfsr_q, lfsr_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [13:0]        elapsed_q, elapsed_d;
  logic [13:0]        result_q, result_d;
  logic [13:0]        best_q, best_d;
  logic [13:0]        disp_q, disp_d;
  logic               go_q, go_d;
  logic               err_q, err_d;
  logic               rv_q, rv_d;
  logic               tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 10'h3FF;
      pre_q     <= '0;
      delay_q   <= '0;
      elapsed_q <= '0;
      result_q  <= '0;
      best_q    <= '0;
      disp_q    <= '0;
      go_q      <= 1'b0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pre_q     <= pre_d;
      delay_q   <= delay_d;
      elapsed_q <= elapsed_d;
      result_q  <= result_d;
      best_q    <= best_d;
      disp_q    <= disp_d;
      go_q      <= go_d;
      err_q     <= err_d;
      rv_q      <= rv_d;
    end
  end

  always_comb begin
    // Fibonacci LFSR for x^10 + x^7 + 1, runs in every state.
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    tick      = (pre_q == PRE_LAST);

    state_d   = state_q;
    delay_d   = delay_q;
    elapsed_d = elapsed_q;
    result_d  = result_q;
    best_d    = best_q;
    rv_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_btn) begin
          state_d = S_WAIT;
          delay_d = DLY_MIN + DLY_W'(lfsr_q);
        end
      end
      S_WAIT: begin
        // A stop press is a false start even if a tick lands on the same cycle.
        if (stop_btn) begin
          state_d = S_FOUL;
        end else if (tick) begin
          if (delay_q == '0) begin
            state_d   = S_GO;
            elapsed_d = '0;
          end else begin
            delay_d = delay_q - 1'b1;
          end
        end
      end
      S_GO: begin
        // Stop freezes the count as it stood; a coinciding tick is dropped.
        if (stop_btn) begin
          state_d  = S_DONE;
          result_d = elapsed_q;
          rv_d     = 1'b1;
          if ((best_q == '0) || (elapsed_q < best_q)) begin
            best_d = elapsed_q;
          end
        end else if (tick) begin
          elapsed_d = elapsed_q + 14'd1;
          if ((elapsed_q + 14'd1) == TIMEOUT_VAL) begin
            state_d = S_TIMEOUT;
          end
        end
      end
      S_DONE, S_FOUL, S_TIMEOUT: begin
        if (start_btn) begin
          state_d = S_WAIT;
          delay_d = DLY_MIN + DLY_W'(lfsr_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Restarting the prescaler on every transition makes each phase start
    // with a full millisecond before its first tick.
    if ((state_d != state_q) || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register and never see the buttons combinationally.
    go_d  = (state_d == S_GO);
    err_d = (state_d == S_FOUL) || (state_d == S_TIMEOUT);
    case (state_d)
      S_IDLE:    disp_d = best_d;
      S_GO:      disp_d = elapsed_d;
      S_DONE:    disp_d = result_d;
      S_TIMEOUT: disp_d = DISP_MAX;
      default:   disp_d = '0;
    endcase
  end

  assign state        = state_q;
  assign go_led       = go_q;
  assign err_led      = err_q;
  assign result_valid = rv_q;
  assign disp_value   = disp_q;
  assign best_time    = best_q;

endmodule
`default_nettype wire

// File: doc/reaction_sequencer.md
REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

Interface
REQ-001 Parameter CLKS_PER_MS, default 50000, clk cycles per millisecond tick.
REQ-002 Parameter MIN_DELAY_MS, default 1000, fixed part of the random pre-GO delay.
REQ-003 Parameter TIMEOUT_MS, default 9999, GO-phase limit, SHALL be <= 9999.
REQ-004 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset.
REQ-006 Port start_btn  input  1  one-cycle pulse, already synchronized and debounced.
REQ-007 Port stop_btn  input  1  one-cycle pulse, already synchronized and debounced.
REQ-008 Port state  output  3  IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4, TIMEOUT=5.
REQ-009 Port go_led  output  1  high only in GO.
REQ-010 Port err_led  output  1  high only in FOUL or TIMEOUT.
REQ-011 Port result_valid  output  1  one-cycle pulse on the cycle DONE is entered.
REQ-012 Port disp_value  output  14  binary value for the 7-segment driver, always <= 9999.
REQ-013 Port best_time  output  14  best (lowest) reaction time in ms; 0 = no record.

Function
REQ-014 Free-running 10-bit LFSR, taps x^10+x^7+1; SHALL advance every cycle in all states.
REQ-015 ms tick: prescaler counts 0..CLKS_PER_MS-1, tick pulses on the terminal count, prescaler cleared to 0 on every state change.
REQ-016 IDLE: start_btn -> WAIT; delay counter loaded with MIN_DELAY_MS + lfsr value (0..1023) in the same cycle.
REQ-017 WAIT: each tick decrements the delay counter; a tick with counter = 0 -> GO, with elapsed cleared to 0.
REQ-018 WAIT: stop_btn -> FOUL (false start); stop_btn SHALL take priority over a simultaneous tick.
REQ-019 GO: each tick increments elapsed (14-bit); elapsed reaching TIMEOUT_MS -> TIMEOUT.
REQ-020 GO: stop_btn -> DONE; result latched = elapsed; a tick in the same cycle SHALL be ignored.
REQ-021 DONE entry: best_time <= result if best_time = 0 or result < best_time; else best_time unchanged.
REQ-022 DONE, FOUL, TIMEOUT: start_btn -> WAIT (new round, per REQ-016 load); stop_btn ignored.
REQ-023 start_btn in WAIT or GO SHALL be ignored; stop_btn in IDLE SHALL be ignored.
REQ-024 start_btn and stop_btn together: IDLE -> WAIT; WAIT -> FOUL; GO -> DONE.
REQ-025 disp_value: IDLE = best_time, WAIT = 0, GO = live elapsed, DONE = result, FOUL = 0, TIMEOUT = 9999.
REQ-026 All outputs SHALL be registered (no combinational path from buttons to outputs).

Reset
REQ-027 rst_n = 0 at a clock edge SHALL force IDLE from any state, including mid-round.
REQ-028 Reset values: state = 0, go_led = 0, err_led = 0, result_valid = 0, disp_value = 0, best_time = 0, prescaler = 0, delay = 0, elapsed = 0, LFSR = 10'h3FF.
REQ-029 best_time SHALL be cleared only by rst_n, never by starting a new round.

Verification (bench: CLKS_PER_MS = 4, MIN_DELAY_MS = 2, TIMEOUT_MS = 20)
REQ-030 Reset release, start pulse -> WAIT next cycle; GO after (2 + lfsr) * 4 + 4 cycles, lfsr value checked against a reference model.
REQ-031 In GO, stop after 7 ticks -> DONE, disp_value = 7, result_valid 1 cycle, best_time = 7; next round result 5 -> best_time = 5; round after with result 9 -> best_time stays 5.
REQ-032 stop pulse during WAIT -> FOUL, err_led = 1, disp_value = 0, best_time unchanged; start -> WAIT.
REQ-033 No stop in GO -> TIMEOUT after 20 ticks, disp_value = 9999, err_led = 1.
REQ-034 stop coincident with tick at elapsed = 3 -> result = 3; start+stop together in IDLE -> WAIT.
REQ-035 rst_n low for 1 cycle during GO -> IDLE, all outputs at REQ-028 values, best_time = 0.
